// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// BOOT_CHECKSUM_EN adds the CHK state used by the checksum-terminated frame format.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef BOOT_CHECKSUM_EN
    CHK,
`endif
    RESP,
    RUN
  } boot_state_t;

  localparam logic [7:0] BOOT_ACK          = 8'h06;
  localparam logic [7:0] BOOT_NAK          = 8'h15;
  localparam logic [7:0] BOOT_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Boot loader signal bundle: UART byte path toward the loader and the
// instruction-memory write port / core release driven by it.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              send;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              load_err;

  modport master (
    input  rx_data, rx_ready, tx_busy,
    output tx_data, send, imem_we, imem_addr, imem_wdata, cpu_run, load_err
  );

  modport slave (
    output rx_data, rx_ready, tx_busy,
    input  tx_data, send, imem_we, imem_addr, imem_wdata, cpu_run, load_err
  );
endinterface

// File: rtl/uart_boot_loader_word_asm.sv
// Little-endian byte-to-word assembler: three low lanes are stored, the fourth
// byte is passed straight through so the full word is available with word_done.
module boot_word_asm (
  input  logic        clk,
  input  logic        clr,
  input  logic        wclr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane;
  logic [23:0] lo_bytes;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      lane     <= '0;
      lo_bytes <= '0;
    end else if (wclr) begin
      lane <= '0;
    end else if (byte_vld) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    lo_bytes[7:0]   <= byte_in;
        2'd1:    lo_bytes[15:8]  <= byte_in;
        2'd2:    lo_bytes[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word_done = byte_vld && !wclr && (lane == 2'd3);
  assign word      = {byte_in, lo_bytes};

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a SYNC/LEN/DATA[/CHK] frame, writes words to imem,
// answers ACK/NAK and releases the core. BOOT_CHECKSUM_EN enables the CHK byte.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = BOOT_SYNC_DEFAULT
) (
  input logic                 clk,
  input logic                 clr,
  uart_boot_loader_if.master  bus
);

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  boot_state_t       state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W:0]   idx;
  logic              resp_ack;
  logic [7:0]        tx_data_r;
  logic              send_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              cpu_run_r;
  logic              load_err_r;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  logic [31:0]     asm_word;
  logic            word_done;
  logic [16:0]     len_rx;
  logic [ADDR_W:0] idx_next;
  logic            last_word;

  // Index is one bit wider than the address so a full-memory image terminates cleanly.
  assign len_rx    = {1'b0, bus.rx_data, len_lo};
  assign idx_next  = idx + 1'b1;
  assign last_word = (17'(idx_next) == {1'b0, len});

  boot_word_asm u_word_asm (
    .clk       (clk),
    .clr       (clr),
    .wclr      (state != DATA),
    .byte_vld  (bus.rx_ready && (state == DATA)),
    .byte_in   (bus.rx_data),
    .word      (asm_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      len_lo       <= '0;
      len          <= '0;
      idx          <= '0;
      resp_ack     <= 1'b0;
      tx_data_r    <= '0;
      send_r       <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= '0;
      cpu_run_r    <= 1'b0;
      load_err_r   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      chk          <= '0;
`endif
    end else begin
      send_r    <= 1'b0;
      imem_we_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_ready && bus.rx_data == SYNC_BYTE) begin
            load_err_r <= 1'b0;
            state      <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (bus.rx_ready) begin
            len_lo <= bus.rx_data;
`ifdef BOOT_CHECKSUM_EN
            chk    <= bus.rx_data;
`endif
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (bus.rx_ready) begin
            len <= len_rx[15:0];
            idx <= '0;
`ifdef BOOT_CHECKSUM_EN
            chk <= chk ^ bus.rx_data;
`endif
            if (len_rx > CAPACITY) begin
              resp_ack <= 1'b0;
              state    <= RESP;
            end else if (len_rx == '0) begin
`ifdef BOOT_CHECKSUM_EN
              state    <= CHK;
`else
              resp_ack <= 1'b1;
              state    <= RESP;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
`ifdef BOOT_CHECKSUM_EN
          if (bus.rx_ready) chk <= chk ^ bus.rx_data;
`endif
          if (word_done) begin
            imem_we_r    <= 1'b1;
            imem_addr_r  <= idx[ADDR_W-1:0];
            imem_wdata_r <= asm_word;
            idx          <= idx_next;
            if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
              state    <= CHK;
`else
              resp_ack <= 1'b1;
              state    <= RESP;
`endif
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CHK: begin
          if (bus.rx_ready) begin
            resp_ack <= (bus.rx_data == chk);
            state    <= RESP;
          end
        end
`endif
        RESP: begin
          if (!bus.tx_busy) begin
            send_r    <= 1'b1;
            tx_data_r <= resp_ack ? BOOT_ACK : BOOT_NAK;
            if (resp_ack) begin
              state <= RUN;
            end else begin
              load_err_r <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        RUN:     cpu_run_r <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data_r;
  assign bus.send       = send_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign bus.cpu_run    = cpu_run_r;
  assign bus.load_err   = load_err_r;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader (ADDR_W=4); follows BOOT_CHECKSUM_EN if defined.
module tb_uart_boot_loader;
  import boot_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(AW)) bus();

  uart_boot_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] wr_addr [$];
  logic [31:0]   wr_data [$];
  int            send_cnt;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
    if (bus.send) send_cnt++;
  end

  typedef struct {
    logic [127:0] fb;
    int           n;
    int           sp;
    logic [7:0]   resp;
    int           nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic         run;
    logic         err;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [127:0] la(input logic [127:0] v, input int n);
    return v << (8 * (16 - n));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    clr          = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    send_cnt = 0;
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [127:0] fb, input int n, input int sp,
                            input bit with_chk, input logic [7:0] chk_mod);
    logic [7:0] x;
    logic [7:0] bt;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      bt = fb[127 - 8*i -: 8];
      if (i > sp) x = x ^ bt;
      put(bt);
    end
`ifdef BOOT_CHECKSUM_EN
    if (with_chk) put(x ^ chk_mod);
`endif
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_send(output bit got, output logic [7:0] tx, output int lat);
    got = 1'b0;
    tx  = 8'h00;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.send) begin
        got = 1'b1;
        tx  = bus.tx_data;
        lat = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  logic [127:0] basic;
  bit           got;
  logic [7:0]   tx;
  int           lat;
  int           busy_sends;
  logic [7:0]   x;

  initial begin
    basic = la(128'hA502001300100093002000, 11);
    vecs[0] = '{fb: basic, n: 11, sp: 0, resp: BOOT_ACK, nwr: 2,
                w0: 32'h00100013, w1: 32'h00200093, run: 1'b1, err: 1'b0};
    vecs[1] = '{fb: la(128'h00FF12A502001300100093002000, 14), n: 14, sp: 3, resp: BOOT_ACK, nwr: 2,
                w0: 32'h00100013, w1: 32'h00200093, run: 1'b1, err: 1'b0};
    vecs[2] = '{fb: la(128'hA51100, 3), n: 3, sp: 0, resp: BOOT_NAK, nwr: 0,
                w0: 32'h0, w1: 32'h0, run: 1'b0, err: 1'b1};
    vecs[3] = '{fb: la(128'hA50000, 3), n: 3, sp: 0, resp: BOOT_ACK, nwr: 0,
                w0: 32'h0, w1: 32'h0, run: 1'b1, err: 1'b0};
    vecs[4] = '{fb: la(128'hA50100EFBEADDE, 7), n: 7, sp: 0, resp: BOOT_ACK, nwr: 1,
                w0: 32'hDEADBEEF, w1: 32'h0, run: 1'b1, err: 1'b0};

    clr = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {31'h0, bus.imem_we} | {31'h0, bus.send} | {31'h0, bus.cpu_run} | {31'h0, bus.load_err}
          | {28'h0, bus.imem_addr} | bus.imem_wdata | {24'h0, bus.tx_data}, 32'h0);

    for (int k = 0; k < 5; k++) begin
      reset_dut();
      check("vec_cpu_run_after_clr", {31'h0, bus.cpu_run}, 32'h0);
      send_frame(vecs[k].fb, vecs[k].n, vecs[k].sp, vecs[k].resp == BOOT_ACK, 8'h00);
      wait_send(got, tx, lat);
      check($sformatf("vec%0d_send_seen", k), {31'h0, got}, 32'h1);
      check($sformatf("vec%0d_resp", k), {24'h0, tx}, {24'h0, vecs[k].resp});
      check($sformatf("vec%0d_run_at_send", k), {31'h0, bus.cpu_run}, 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d_run_next", k), {31'h0, bus.cpu_run}, {31'h0, vecs[k].run});
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_nwr", k), wr_addr.size(), vecs[k].nwr);
      check($sformatf("vec%0d_load_err", k), {31'h0, bus.load_err}, {31'h0, vecs[k].err});
      if (vecs[k].nwr >= 1 && wr_addr.size() >= 1) begin
        check($sformatf("vec%0d_addr0", k), {28'h0, wr_addr[0]}, 32'h0);
        check($sformatf("vec%0d_data0", k), wr_data[0], vecs[k].w0);
      end
      if (vecs[k].nwr >= 2 && wr_addr.size() >= 2) begin
        check($sformatf("vec%0d_addr1", k), {28'h0, wr_addr[1]}, 32'h1);
        check($sformatf("vec%0d_data1", k), wr_data[1], vecs[k].w1);
      end
    end

    // NAK followed by a good frame: load_err drops on the accepted sync byte.
    reset_dut();
    send_frame(la(128'hA51100, 3), 3, 0, 1'b0, 8'h00);
    wait_send(got, tx, lat);
    check("nak_resp", {24'h0, tx}, {24'h0, BOOT_NAK});
    repeat (2) @(negedge clk);
    check("nak_load_err", {31'h0, bus.load_err}, 32'h1);
    put(8'h00);
    put(8'hA5);
    check("err_clear_on_sync", {31'h0, bus.load_err}, 32'h0);
    send_frame(basic << 8, 10, -1, 1'b1, 8'h00);
    wait_send(got, tx, lat);
    check("recover_resp", {24'h0, tx}, {24'h0, BOOT_ACK});
    repeat (2) @(negedge clk);
    check("recover_run", {31'h0, bus.cpu_run}, 32'h1);
    check("recover_nwr", wr_addr.size(), 2);

    // Transmitter busy on entry to RESP.
    reset_dut();
    bus.tx_busy = 1'b1;
    send_frame(basic, 11, 0, 1'b1, 8'h00);
    busy_sends = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.send) busy_sends++;
      @(negedge clk);
    end
    check("busy_no_send", busy_sends, 0);
    bus.tx_busy = 1'b0;
    wait_send(got, tx, lat);
    check("busy_send_latency", lat, 1);
    check("busy_resp", {24'h0, tx}, {24'h0, BOOT_ACK});

    // Full-capacity image: N == 2^ADDR_W is legal and ends at the top address.
    reset_dut();
    x = 8'h10;
    put(8'hA5); put(8'h10); put(8'h00);
    for (int w = 0; w < 16; w++) begin
      put(8'(w)); put(8'h00); put(8'h00); put(8'h00);
      x = x ^ 8'(w);
    end
`ifdef BOOT_CHECKSUM_EN
    put(x);
`endif
    bus.rx_ready = 1'b0;
    wait_send(got, tx, lat);
    check("full_resp", {24'h0, tx}, {24'h0, BOOT_ACK});
    repeat (3) @(negedge clk);
    check("full_nwr", wr_addr.size(), 16);
    if (wr_addr.size() == 16) begin
      check("full_last_addr", {28'h0, wr_addr[15]}, 32'hF);
      check("full_last_data", wr_data[15], 32'h0000000F);
    end

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: words land, but the frame is refused.
    reset_dut();
    send_frame(basic, 11, 0, 1'b1, 8'h01);
    wait_send(got, tx, lat);
    check("badchk_resp", {24'h0, tx}, {24'h0, BOOT_NAK});
    repeat (3) @(negedge clk);
    check("badchk_nwr", wr_addr.size(), 2);
    check("badchk_run", {31'h0, bus.cpu_run}, 32'h0);
    check("badchk_err", {31'h0, bus.load_err}, 32'h1);
`endif

    // clr in the middle of the data phase, then a full reload and RUN immunity.
    reset_dut();
    send_frame(la(128'hA50200130010009300, 9), 9, 0, 1'b0, 8'h00);
    @(negedge clk);
    check("abort_nwr_before", wr_addr.size(), 1);
    clr = 1'b1;
    @(negedge clk);
    check("abort_outputs",
          {31'h0, bus.imem_we} | {31'h0, bus.send} | {31'h0, bus.cpu_run} | {31'h0, bus.load_err}
          | {28'h0, bus.imem_addr} | bus.imem_wdata | {24'h0, bus.tx_data}, 32'h0);
    wr_addr.delete();
    wr_data.delete();
    clr = 1'b0;
    @(negedge clk);
    send_frame(basic, 11, 0, 1'b1, 8'h00);
    wait_send(got, tx, lat);
    check("reload_resp", {24'h0, tx}, {24'h0, BOOT_ACK});
    repeat (3) @(negedge clk);
    check("reload_nwr", wr_addr.size(), 2);
    if (wr_addr.size() >= 1) begin
      check("reload_addr0", {28'h0, wr_addr[0]}, 32'h0);
      check("reload_data0", wr_data[0], 32'h00100013);
    end
    wr_addr.delete();
    wr_data.delete();
    send_cnt = 0;
    send_frame(la(128'hA5010011223344, 7), 7, 0, 1'b1, 8'h00);
    repeat (10) @(negedge clk);
    check("run_no_writes", wr_addr.size(), 0);
    check("run_no_send", send_cnt, 0);
    check("run_stays", {31'h0, bus.cpu_run}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
